vpe_operand_dispatcher: RTL and testbench
=========================================

// Module: vpe_operand_dispatcher
// PURPOSE
// - Upstream feeder for the pipe-staged VPE array (PIPE_STAGE parallel reconf_tile lanes).
// - Accepts a stream of jobs (vec1, vec2, scal, mode) over valid/ready.
// - Dispatches jobs round-robin into per-lane operand registers and holds them stable for LANE_CYCLES (multicycle path).
// - Captures each lane's Vec/Scal result and returns results in strict issue order over valid/ready.
// PARAMETERS
// - PIPE_STAGE   3    number of VPE lanes driven
// - TILE_SIZE    128  elements per vector
// - MUL_WIDTH    16   bits per element / scalar
// - LANE_CYCLES  3    cycles a lane holds operands before its result is sampled; legal >=1
// PORTS
// - clk_i        in   1                          clock, all logic rising-edge
// - rst_i        in   1                          synchronous, active-high reset
// - in_valid_i   in   1                          job valid
// - in_ready_o   out  1                          job accepted when in_valid_i && in_ready_o
// - in_vec1_i    in   TILE_SIZE*MUL_WIDTH        vector operand 1
// - in_vec2_i    in   TILE_SIZE*MUL_WIDTH        vector operand 2
// - in_scal_i    in   MUL_WIDTH                  scalar operand
// - in_mode_i    in   1                          1: scalar result, 0: vector result
// - operand1_o   out  PIPE_STAGE*TILE_SIZE*MUL_WIDTH  per-lane vec1 to VPE
// - operand2_o   out  PIPE_STAGE*TILE_SIZE*MUL_WIDTH  per-lane vec2 to VPE
// - operand3_o   out  PIPE_STAGE*MUL_WIDTH       per-lane scalar to VPE
// - mode_o       out  PIPE_STAGE                 per-lane mode to VPE
// - Vec_i        in   PIPE_STAGE*TILE_SIZE*MUL_WIDTH  per-lane vector result from VPE
// - Scal_i       in   PIPE_STAGE*MUL_WIDTH       per-lane scalar result from VPE
// - out_valid_o  out  1                          result valid
// - out_ready_i  in   1                          result consumed when out_valid_o && out_ready_i
// - out_vec_o    out  TILE_SIZE*MUL_WIDTH        captured vector result
// - out_scal_o   out  MUL_WIDTH                  captured scalar result
// - out_mode_o   out  1                          mode of the returned job
// BEHAVIOUR
// - Lane FSM, one per lane:
//   - IDLE -> COMPUTE on accept into that lane; counter loaded with LANE_CYCLES-1.
//   - COMPUTE: counter decrements each cycle; at counter==0 it samples Vec_i/Scal_i[lane] into a result register -> DONE.
//   - DONE -> IDLE on output handshake.
// - disp_ptr, out_ptr: 0..PIPE_STAGE-1. Each increments with wrap to 0 on its own handshake only.
// - in_ready_o = (lane[disp_ptr]==IDLE), taken from registered state only; no same-cycle bypass of a lane being freed.
// - out_valid_o = (lane[out_ptr]==DONE). out_* are muxed from the lane[out_ptr] result regs and are stable while valid && !ready.
// - Latency: accept at edge E -> out_valid_o high in the cycle after edge E+LANE_CYCLES.
// - Per-lane turnaround is LANE_CYCLES+2 cycles. Sustained rate is PIPE_STAGE/(LANE_CYCLES+2) jobs/cycle (3/5 at defaults).
// - Operand regs load only on accept and hold in every state (no toggling).
// - Simultaneous accept and output on different lanes are independent.
// - Simultaneous accept and output on the same lane cannot occur: IDLE vs DONE are exclusive.
// - All lanes busy: in_ready_o=0. Inputs are ignored and no state changes.
// - Reset (including mid-operation):
//   - All lanes IDLE; pointers 0; in-flight jobs and results dropped.
//   - Operand, mode and result registers 0; in_ready_o=1 and out_valid_o=0 from the first cycle after reset.
// CONFIGURATION
// - VPE_DISPATCH_PERF_EN defined: adds outputs perf_jobs_o[31:0] and perf_stall_o[31:0].
//   - perf_jobs_o counts accepted jobs; perf_stall_o counts cycles with in_valid_i && !in_ready_o.
//   - Both are 0 on reset and saturate at 32'hFFFF_FFFF.
// - Undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Bench stub for the VPE: Vec_i[l]=operand1_o[l]; Scal_i[l]=operand3_o[l]+1.
// - Single job: vec1 elements = 16'h0011, scal=16'h0005, mode=1, out_ready_i=1.
//   -> out_valid_o exactly 3 cycles after accept; out_scal_o=16'h0006, out_vec_o elements 16'h0011, out_mode_o=1.
// - Burst: 6 jobs with scal 0..5, in_valid_i held, out_ready_i=1.
//   -> lanes 0,1,2,0,1,2 used; outputs in order with scal 1..6; jobs 4..6 stall until a lane frees.
// - Backpressure: out_ready_i=0 while 4 jobs are offered.
//   -> 3 accepted, then in_ready_o=0 and out_* stable; release -> results 1,2,3 in order, then the 4th accepted.
// - Reset mid-run: assert rst_i for 1 cycle with 2 lanes in COMPUTE.
//   -> out_valid_o never rises for those jobs; next job goes to lane 0 with 3-cycle latency.
// - Wrap: 300 jobs with random out_ready_i -> issue order preserved, no loss, no duplicates, pointers wrap cleanly.
// - Perf (macro on): 4 jobs under the backpressure scenario -> perf_jobs_o=4; perf_stall_o equals the in_ready_o-low cycles counted by the bench.

Source files
------------

// File: rtl/vpe_operand_dispatcher.sv
// Round-robin operand dispatcher for PIPE_STAGE VPE lanes with in-order result return.
// Optional perf counters (perf_jobs_o, perf_stall_o) are built when VPE_DISPATCH_PERF_EN is defined.
module vpe_operand_dispatcher #(
  parameter int unsigned PIPE_STAGE  = 3,
  parameter int unsigned TILE_SIZE   = 128,
  parameter int unsigned MUL_WIDTH   = 16,
  parameter int unsigned LANE_CYCLES = 3
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      in_valid_i,
  output logic                                      in_ready_o,
  input  logic [TILE_SIZE*MUL_WIDTH-1:0]            in_vec1_i,
  input  logic [TILE_SIZE*MUL_WIDTH-1:0]            in_vec2_i,
  input  logic [MUL_WIDTH-1:0]                      in_scal_i,
  input  logic                                      in_mode_i,
  output logic [PIPE_STAGE*TILE_SIZE*MUL_WIDTH-1:0] operand1_o,
  output logic [PIPE_STAGE*TILE_SIZE*MUL_WIDTH-1:0] operand2_o,
  output logic [PIPE_STAGE*MUL_WIDTH-1:0]           operand3_o,
  output logic [PIPE_STAGE-1:0]                     mode_o,
  input  logic [PIPE_STAGE*TILE_SIZE*MUL_WIDTH-1:0] Vec_i,
  input  logic [PIPE_STAGE*MUL_WIDTH-1:0]           Scal_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [TILE_SIZE*MUL_WIDTH-1:0]            out_vec_o,
  output logic [MUL_WIDTH-1:0]                      out_scal_o,
  output logic                                      out_mode_o
`ifdef VPE_DISPATCH_PERF_EN
  ,
  output logic [31:0]                               perf_jobs_o,
  output logic [31:0]                               perf_stall_o
`endif
);

  localparam int unsigned TW = TILE_SIZE * MUL_WIDTH;
  localparam int unsigned PW = (PIPE_STAGE > 1) ? $clog2(PIPE_STAGE) : 1;
  localparam int unsigned CW = (LANE_CYCLES > 1) ? $clog2(LANE_CYCLES) : 1;

  typedef enum logic [1:0] {
    L_IDLE,
    L_COMPUTE,
    L_DONE
  } lane_state_e;

  logic [PW-1:0] disp_ptr_q, disp_ptr_d;
  logic [PW-1:0] out_ptr_q, out_ptr_d;
  logic          accept;
  logic          retire;

  lane_state_e          lane_st       [PIPE_STAGE];
  logic [TW-1:0]        lane_res_vec  [PIPE_STAGE];
  logic [MUL_WIDTH-1:0] lane_res_scal [PIPE_STAGE];
  logic                 lane_mode     [PIPE_STAGE];

  // Handshakes depend only on registered lane state, never on a lane freed this cycle.
  assign in_ready_o  = (lane_st[disp_ptr_q] == L_IDLE);
  assign out_valid_o = (lane_st[out_ptr_q] == L_DONE);
  assign accept      = in_valid_i && in_ready_o;
  assign retire      = out_valid_o && out_ready_i;

  assign out_vec_o  = lane_res_vec[out_ptr_q];
  assign out_scal_o = lane_res_scal[out_ptr_q];
  assign out_mode_o = lane_mode[out_ptr_q];

  always_comb begin
    disp_ptr_d = disp_ptr_q;
    out_ptr_d  = out_ptr_q;
    if (accept) begin
      disp_ptr_d = (disp_ptr_q == PW'(PIPE_STAGE - 1)) ? '0 : disp_ptr_q + PW'(1);
    end
    if (retire) begin
      out_ptr_d = (out_ptr_q == PW'(PIPE_STAGE - 1)) ? '0 : out_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_ptr_q <= '0;
      out_ptr_q  <= '0;
    end else begin
      disp_ptr_q <= disp_ptr_d;
      out_ptr_q  <= out_ptr_d;
    end
  end

  for (genvar g = 0; g < PIPE_STAGE; g++) begin : g_lane
    lane_state_e          st_q;
    logic [CW-1:0]        cnt_q;
    logic [TW-1:0]        op1_q;
    logic [TW-1:0]        op2_q;
    logic [MUL_WIDTH-1:0] op3_q;
    logic                 mode_q;
    logic [TW-1:0]        res_vec_q;
    logic [MUL_WIDTH-1:0] res_scal_q;
    logic                 load;
    logic                 release_lane;

    assign load         = accept && (disp_ptr_q == PW'(g));
    assign release_lane = retire && (out_ptr_q == PW'(g));

    // Operands are written only on accept so the VPE sees a stable multicycle input.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        st_q       <= L_IDLE;
        cnt_q      <= '0;
        op1_q      <= '0;
        op2_q      <= '0;
        op3_q      <= '0;
        mode_q     <= 1'b0;
        res_vec_q  <= '0;
        res_scal_q <= '0;
      end else begin
        if (load) begin
          op1_q  <= in_vec1_i;
          op2_q  <= in_vec2_i;
          op3_q  <= in_scal_i;
          mode_q <= in_mode_i;
        end
        case (st_q)
          L_IDLE: begin
            if (load) begin
              st_q  <= L_COMPUTE;
              cnt_q <= CW'(LANE_CYCLES - 1);
            end
          end
          L_COMPUTE: begin
            if (cnt_q == '0) begin
              res_vec_q  <= Vec_i[g*TW +: TW];
              res_scal_q <= Scal_i[g*MUL_WIDTH +: MUL_WIDTH];
              st_q       <= L_DONE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          L_DONE: begin
            if (release_lane) begin
              st_q <= L_IDLE;
            end
          end
          default: st_q <= L_IDLE;
        endcase
      end
    end

    assign operand1_o[g*TW +: TW]               = op1_q;
    assign operand2_o[g*TW +: TW]               = op2_q;
    assign operand3_o[g*MUL_WIDTH +: MUL_WIDTH] = op3_q;
    assign mode_o[g]                            = mode_q;
    assign lane_st[g]                           = st_q;
    assign lane_res_vec[g]                      = res_vec_q;
    assign lane_res_scal[g]                     = res_scal_q;
    assign lane_mode[g]                         = mode_q;
  end

`ifdef VPE_DISPATCH_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_jobs_d  = perf_jobs_q;
    perf_stall_d = perf_stall_q;
    if (accept && (perf_jobs_q != '1)) begin
      perf_jobs_d = perf_jobs_q + 32'd1;
    end
    if (in_valid_i && !in_ready_o && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_jobs_q  <= perf_jobs_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_jobs_o  = perf_jobs_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_vpe_operand_dispatcher.sv
// Bench for vpe_operand_dispatcher: VPE stub plus a job-level reference model
// (issue/retire counts and accept timestamps) that predicts handshakes and results.
module tb_vpe_operand_dispatcher;

  localparam int unsigned P     = 3;
  localparam int unsigned TS    = 128;
  localparam int unsigned W     = 16;
  localparam int unsigned LC    = 3;
  localparam int unsigned TW    = TS * W;
  localparam int unsigned DEPTH = 512;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [TW-1:0]   in_vec1_i = '0;
  logic [TW-1:0]   in_vec2_i = '0;
  logic [W-1:0]    in_scal_i = '0;
  logic            in_mode_i = 1'b0;
  logic [P*TW-1:0] operand1_o;
  logic [P*TW-1:0] operand2_o;
  logic [P*W-1:0]  operand3_o;
  logic [P-1:0]    mode_o;
  logic [P*TW-1:0] Vec_i;
  logic [P*W-1:0]  Scal_i;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [TW-1:0]   out_vec_o;
  logic [W-1:0]    out_scal_o;
  logic            out_mode_o;
`ifdef VPE_DISPATCH_PERF_EN
  logic [31:0]     perf_jobs_o;
  logic [31:0]     perf_stall_o;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  vpe_operand_dispatcher #(
    .PIPE_STAGE (P),
    .TILE_SIZE  (TS),
    .MUL_WIDTH  (W),
    .LANE_CYCLES(LC)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_vec1_i   (in_vec1_i),
    .in_vec2_i   (in_vec2_i),
    .in_scal_i   (in_scal_i),
    .in_mode_i   (in_mode_i),
    .operand1_o  (operand1_o),
    .operand2_o  (operand2_o),
    .operand3_o  (operand3_o),
    .mode_o      (mode_o),
    .Vec_i       (Vec_i),
    .Scal_i      (Scal_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_vec_o   (out_vec_o),
    .out_scal_o  (out_scal_o),
    .out_mode_o  (out_mode_o)
`ifdef VPE_DISPATCH_PERF_EN
    ,
    .perf_jobs_o (perf_jobs_o),
    .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // VPE stub: vector result echoes vec1, scalar result is scal + 1.
  assign Vec_i = operand1_o;
  for (genvar g = 0; g < P; g++) begin : g_stub
    assign Scal_i[g*W +: W] = operand3_o[g*W +: W] + 16'd1;
  end

  // Reference model: job n goes to lane n%P; that lane is free once job n-P retired;
  // a job's result is visible LC cycles after its accept edge, retired strictly in order.
  int unsigned cyc = 0, acc = 0, ret = 0, n_stall = 0;
  int unsigned acc_cyc [DEPTH];
  logic [TW-1:0] j_vec  [DEPTH];
  logic [W-1:0]  j_scal [DEPTH];
  logic          j_mode [DEPTH];
  logic exp_ready = 1'b0;
  logic exp_valid = 1'b0;

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (rst_i) begin
      acc = 0; ret = 0; n_stall = 0;
    end else begin
      if (exp_valid && out_ready_i) ret = ret + 1;
      if (in_valid_i && exp_ready) begin
        j_vec[acc % DEPTH]   = in_vec1_i;
        j_scal[acc % DEPTH]  = in_scal_i;
        j_mode[acc % DEPTH]  = in_mode_i;
        acc_cyc[acc % DEPTH] = cyc;
        acc = acc + 1;
      end else if (in_valid_i) begin
        n_stall = n_stall + 1;
      end
    end
    exp_ready = (ret + P > acc);
    exp_valid = (ret < acc) && (cyc - acc_cyc[ret % DEPTH] >= LC);
  end

  function automatic logic [TW-1:0] rand_vec();
    logic [TW-1:0] v;
    for (int i = 0; i < TW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    in_valid_i = 1'b1; in_vec1_i = rand_vec(); in_scal_i = 16'h1234; in_mode_i = 1'b1;
    @(negedge clk_i);
    do_reset();
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    total++; if (operand1_o !== '0) begin bad++; $display("FAIL reset_operand1 not zero"); end
    total++; if (operand3_o !== '0) begin bad++; $display("FAIL reset_operand3 got=%h exp=0", operand3_o); end
    total++; if (mode_o !== '0) begin bad++; $display("FAIL reset_mode got=%b exp=0", mode_o); end
    total++; if (out_scal_o !== '0) begin bad++; $display("FAIL reset_out_scal got=%h exp=0", out_scal_o); end
`ifdef VPE_DISPATCH_PERF_EN
    total++; if (perf_jobs_o !== 32'd0) begin bad++; $display("FAIL reset_perf_jobs got=%0d exp=0", perf_jobs_o); end
    total++; if (perf_stall_o !== 32'd0) begin bad++; $display("FAIL reset_perf_stall got=%0d exp=0", perf_stall_o); end
`endif
  endtask

  task automatic test_single();
    logic [TW-1:0] v;
    int unsigned lat;
    do_reset();
    v = {TS{16'h0011}};
    out_ready_i = 1'b1;
    in_vec1_i = v; in_vec2_i = rand_vec(); in_scal_i = 16'h0005; in_mode_i = 1'b1; in_valid_i = 1'b1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", in_ready_o); end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    total++; if (operand1_o[0 +: TW] !== v || mode_o[0] !== 1'b1)
      begin bad++; $display("FAIL single_lane0_operands mode got=%b exp=1", mode_o[0]); end
    lat = 0;
    while (!out_valid_o && lat < 20) begin @(negedge clk_i); lat++; end
    total++; if (lat !== LC) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, LC); end
    total++; if (out_scal_o !== 16'h0006) begin bad++; $display("FAIL single_scal got=%h exp=0006", out_scal_o); end
    total++; if (out_vec_o !== v) begin bad++; $display("FAIL single_vec got=%h exp=0011", out_vec_o[15:0]); end
    total++; if (out_mode_o !== 1'b1) begin bad++; $display("FAIL single_mode got=%b exp=1", out_mode_o); end
    @(negedge clk_i);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_burst();
    int unsigned prev_acc, got, k;
    logic stall_seen;
    do_reset();
    out_ready_i = 1'b1; got = 0; k = 0; stall_seen = 1'b0; prev_acc = 0;
    while ((got < 6) && (k < 200)) begin
      if (acc > prev_acc) begin
        total++;
        if (operand3_o[((acc-1) % P)*W +: W] !== 16'(acc-1))
          begin bad++; $display("FAIL burst_lane job=%0d got=%h exp=%h", acc-1, operand3_o[((acc-1) % P)*W +: W], 16'(acc-1)); end
      end
      total++; if (in_ready_o !== exp_ready) begin bad++; $display("FAIL burst_ready cyc=%0d got=%b exp=%b", k, in_ready_o, exp_ready); end
      total++; if (out_valid_o !== exp_valid) begin bad++; $display("FAIL burst_valid cyc=%0d got=%b exp=%b", k, out_valid_o, exp_valid); end
      if (exp_valid) begin
        total++;
        if (out_scal_o !== 16'(got + 1) || out_vec_o !== j_vec[ret % DEPTH] || out_mode_o !== j_mode[ret % DEPTH])
          begin bad++; $display("FAIL burst_data idx=%0d scal got=%h exp=%h", got, out_scal_o, 16'(got + 1)); end
        got++;
      end
      if (in_valid_i && !exp_ready) stall_seen = 1'b1;
      if (acc < 6) begin
        in_valid_i = 1'b1; in_scal_i = 16'(acc); in_vec1_i = rand_vec(); in_vec2_i = rand_vec(); in_mode_i = acc[0];
      end else in_valid_i = 1'b0;
      prev_acc = acc;
      @(negedge clk_i); k++;
    end
    in_valid_i = 1'b0;
    total++; if (got !== 6) begin bad++; $display("FAIL burst_count got=%0d exp=6", got); end
    total++; if (stall_seen !== 1'b1) begin bad++; $display("FAIL burst_stall got=%b exp=1", stall_seen); end
  endtask

  task automatic test_backpressure();
    int unsigned k, got, stall;
    logic [W-1:0] held;
    do_reset();
    out_ready_i = 1'b0; got = 0; stall = 0; held = '0;
    for (int i = 0; i < 12; i++) begin
      total++; if (in_ready_o !== exp_ready) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", i, in_ready_o, exp_ready); end
      total++; if (out_valid_o !== exp_valid) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, out_valid_o, exp_valid); end
      if (exp_valid) begin
        if (held == '0) held = out_scal_o;
        total++; if (out_scal_o !== 16'h0001) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=0001", i, out_scal_o); end
      end
      if (acc < 4) begin
        in_valid_i = 1'b1; in_scal_i = 16'(acc); in_vec1_i = rand_vec(); in_mode_i = 1'b1;
      end else in_valid_i = 1'b0;
      if (in_valid_i && !exp_ready) stall++;
      @(negedge clk_i);
    end
    total++; if (acc !== 3) begin bad++; $display("FAIL bp_accepted got=%0d exp=3", acc); end
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready_o); end
    out_ready_i = 1'b1; k = 0;
    while ((got < 4) && (k < 60)) begin
      total++; if (in_ready_o !== exp_ready) begin bad++; $display("FAIL bp_rel_ready cyc=%0d got=%b exp=%b", k, in_ready_o, exp_ready); end
      total++; if (out_valid_o !== exp_valid) begin bad++; $display("FAIL bp_rel_valid cyc=%0d got=%b exp=%b", k, out_valid_o, exp_valid); end
      if (exp_valid) begin
        total++; if (out_scal_o !== 16'(got + 1) || out_vec_o !== j_vec[ret % DEPTH])
          begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, out_scal_o, 16'(got + 1)); end
        got++;
      end
      if (acc < 4) begin
        in_valid_i = 1'b1; in_scal_i = 16'(acc); in_vec1_i = rand_vec(); in_mode_i = 1'b1;
      end else in_valid_i = 1'b0;
      if (in_valid_i && !exp_ready) stall++;
      @(negedge clk_i); k++;
    end
    in_valid_i = 1'b0;
    total++; if (got !== 4) begin bad++; $display("FAIL bp_results got=%0d exp=4", got); end
`ifdef VPE_DISPATCH_PERF_EN
    total++; if (perf_jobs_o !== 32'd4) begin bad++; $display("FAIL perf_jobs got=%0d exp=4", perf_jobs_o); end
    total++; if (perf_stall_o !== stall) begin bad++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_o, stall); end
`endif
  endtask

  task automatic test_reset_mid();
    int unsigned highs, lat;
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_scal_i = 16'h0000; in_vec1_i = rand_vec(); in_mode_i = 1'b0;
    @(negedge clk_i);
    in_scal_i = 16'h0001; in_vec1_i = rand_vec();
    @(negedge clk_i);
    in_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready_o); end
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_o !== 1'b0) highs++;
      @(negedge clk_i);
    end
    total++; if (highs !== 0) begin bad++; $display("FAIL midrst_dropped got=%0d exp=0", highs); end
    in_valid_i = 1'b1; in_scal_i = 16'h0009; in_vec1_i = rand_vec(); in_mode_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    total++; if (operand3_o[0 +: W] !== 16'h0009) begin bad++; $display("FAIL midrst_lane0 got=%h exp=0009", operand3_o[0 +: W]); end
    lat = 0;
    while (!out_valid_o && lat < 20) begin @(negedge clk_i); lat++; end
    total++; if (lat !== LC) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LC); end
    total++; if (out_scal_o !== 16'h000a) begin bad++; $display("FAIL midrst_scal got=%h exp=000a", out_scal_o); end
    @(negedge clk_i);
  endtask

  task automatic test_wrap();
    int unsigned k, errs;
    do_reset();
    k = 0; errs = 0;
    while ((ret < 300) && (k < 5000)) begin
      total++; if (in_ready_o !== exp_ready || out_valid_o !== exp_valid) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL wrap_handshake cyc=%0d ready=%b/%b valid=%b/%b", k, in_ready_o, exp_ready, out_valid_o, exp_valid);
      end
      if (exp_valid) begin
        total++;
        if ({out_mode_o, out_scal_o, out_vec_o} !== {j_mode[ret % DEPTH], j_scal[ret % DEPTH] + 16'd1, j_vec[ret % DEPTH]}) begin
          bad++; errs++;
          if (errs < 5) $display("FAIL wrap_data job=%0d scal got=%h exp=%h", ret, out_scal_o, j_scal[ret % DEPTH] + 16'd1);
        end
      end
      out_ready_i = ($urandom_range(0, 2) != 0);
      if (acc < 300 && $urandom_range(0, 3) != 0) begin
        in_valid_i = 1'b1; in_vec1_i = rand_vec(); in_vec2_i = rand_vec();
        in_scal_i = 16'($urandom); in_mode_i = 1'($urandom);
      end else in_valid_i = 1'b0;
      @(negedge clk_i); k++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    total++; if (ret !== 300 || acc !== 300) begin bad++; $display("FAIL wrap_count retired=%0d issued=%0d exp=300", ret, acc); end
    @(negedge clk_i);
    total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin bad++; $display("FAIL wrap_idle valid=%b ready=%b", out_valid_o, in_ready_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
